lu_recompose: RTL
=================

LU_RECOMPOSE -- requirements
Module: lu_recompose

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension.
REQ-002 SHALL have parameter W, default 32, element width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin recomposition, sampled in IDLE only.
REQ-006 SHALL have port L_in  input  512  lower-triangular factor L, row-major, element (r,c) at [(r*4+c)*32 +: 32].
REQ-007 SHALL have port U_in  input  512  upper-triangular factor U, same packing.
REQ-008 SHALL have port busy  output  1  high while a recomposition is in progress (MAC state).
REQ-009 SHALL have port done  output  1  one-cycle pulse; A_out valid.
REQ-010 SHALL have port A_out  output  512  product A = L*U, same packing.

Function
REQ-011 SHALL implement FSM states IDLE, MAC, DONE; reset state IDLE.
REQ-012 SHALL, in IDLE with start=1, capture L_in and U_in into internal registers at that edge, clear A_out, set i=j=k=0 and acc=0, and move to MAC.
REQ-013 SHALL ignore start in MAC and DONE; L_in and U_in changes after capture SHALL NOT affect the result.
REQ-014 SHALL, each MAC cycle, form sum = acc + L[i][k]*U[k][j], with signed two's-complement operands, product and sum truncated to low 32 bits (wrap-around, no saturation).
REQ-015 SHALL, when k<3, set acc=sum and k=k+1; when k=3, write sum to A_out element (i,j), clear acc, clear k, and advance j, then i (row-major order).
REQ-016 SHALL compute all 4 terms per element (64 MAC cycles total) regardless of operand values; no zero-skipping, no triangularity check.
REQ-017 SHALL move to DONE on the cycle element (3,3) is written; DONE SHALL last exactly one cycle then return to IDLE.
REQ-018 SHALL assert done only in DONE: start sampled at edge 0 -> MAC on edges 1..64 -> done high during cycle after edge 64 (latency 65 cycles).
REQ-019 SHALL hold busy=1 exactly while in MAC (64 cycles), 0 otherwise.
REQ-020 SHALL hold A_out stable from done until next accepted start; during MAC, partially written values are not valid.
REQ-021 SHALL accept a new start in the IDLE cycle immediately following DONE (back-to-back operations, 66-cycle period).

Reset
REQ-022 SHALL, on rst=1 at a rising edge, force state IDLE, busy=0, done=0, A_out=0, acc=0, i=j=k=0, internal L/U copies=0.
REQ-023 SHALL abort any in-progress operation on rst; no done pulse SHALL follow for the aborted operation.
REQ-024 SHALL give rst priority over start in the same cycle.

Structure
REQ-025 SHALL place N, W, bus width (N*N*W=512), index width, and the FSM state encoding in a shared package lu_pkg used by the LU blocks.
REQ-026 SHALL implement the multiply-accumulate datapath as one sub-module lu_mac (inputs acc, a, b; output sum; combinational, 32-bit wrap).

Verification
REQ-027 Identity: L=I, U=I, start pulse one cycle -> A_out=I, done one cycle exactly 65 cycles after start edge, busy high 64 cycles.
REQ-028 Typical: L rows [1,0,0,0],[2,1,0,0],[0,0,1,0],[0,0,0,1]; U rows [4,1,0,0],[0,2,0,0],[0,0,3,0],[0,0,0,5] -> A rows [4,1,0,0],[8,4,0,0],[0,0,3,0],[0,0,0,5].
REQ-029 Signed/wrap: L[1][0]=-1 (0xFFFFFFFF), U[0][0]=3, otherwise identity -> A[1][0]=0xFFFFFFFD; L[0][0]=U[0][0]=0x00010000 -> A[0][0]=0x00000000.
REQ-030 Start while busy: second start pulse 10 cycles after first, L_in/U_in changed -> single done at 65 cycles, result from first captured operands only.
REQ-031 Reset mid-operation: rst at cycle 30 of MAC -> busy=0, done never pulses, A_out=0; subsequent start with REQ-028 operands -> correct A after 65 cycles.
REQ-032 Back-to-back: start held high continuously -> operations accepted every 66 cycles, each done followed by correct A_out.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared constants and FSM encoding for the LU factor blocks.
package lu_pkg;

    localparam int LU_N     = 4;
    localparam int LU_W     = 32;
    localparam int LU_BUS_W = LU_N * LU_N * LU_W;
    localparam int LU_IDX_W = $clog2(LU_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } lu_state_t;

endpackage

// File: rtl/lu_mac.sv
// Combinational signed multiply-accumulate, wrapping at W bits.
module lu_mac #(
    parameter int W = 32
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic signed [W-1:0] prod;

    // Low W bits of the product are identical for signed and unsigned operands.
    assign prod = $signed(a) * $signed(b);
    assign sum  = acc + W'(prod);

endmodule

// File: rtl/lu_recompose.sv
// Sequential recomposition A = L*U: one multiply-accumulate per cycle, row-major.
module lu_recompose
    import lu_pkg::*;
#(
    parameter int N = LU_N,
    parameter int W = LU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N*N*W-1:0] L_in,
    input  logic [N*N*W-1:0] U_in,
    output logic             busy,
    output logic             done,
    output logic [N*N*W-1:0] A_out
);

    localparam int BUS_W = N * N * W;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;

    lu_state_t        state, state_n;
    logic [BUS_W-1:0] l_q, u_q, a_q;
    logic [W-1:0]     acc, sum, mac_a, mac_b;
    logic [IW-1:0]    i, j, k;
    logic             k_last, j_last, i_last;
    int               l_base, u_base, a_base;

    assign k_last = (k == IW'(N - 1));
    assign j_last = (j == IW'(N - 1));
    assign i_last = (i == IW'(N - 1));

    always_comb begin
        l_base = ((int'(i) * N) + int'(k)) * W;
        u_base = ((int'(k) * N) + int'(j)) * W;
        a_base = ((int'(i) * N) + int'(j)) * W;
        mac_a  = l_q[l_base +: W];
        mac_b  = u_q[u_base +: W];
    end

    lu_mac #(.W(W)) u_mac (
        .acc (acc),
        .a   (mac_a),
        .b   (mac_b),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (start) state_n = MAC;
            MAC: begin
                busy = 1'b1;
                if (k_last && j_last && i_last) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_q <= '0;
            u_q <= '0;
            a_q <= '0;
            acc <= '0;
            i   <= '0;
            j   <= '0;
            k   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    l_q <= L_in;
                    u_q <= U_in;
                    a_q <= '0;
                    acc <= '0;
                    i   <= '0;
                    j   <= '0;
                    k   <= '0;
                end
                MAC: begin
                    if (k_last) begin
                        a_q[a_base +: W] <= sum;
                        acc <= '0;
                        k   <= '0;
                        if (j_last) begin
                            j <= '0;
                            i <= i_last ? '0 : i + 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        acc <= sum;
                        k   <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign A_out = a_q;

endmodule
